qam16_tx_mapper: RTL and testbench
==================================

Name: qam16_tx_mapper

Overview:
- QAM16 transmit-side symbol mapper. It feeds the shaping filter and upconverter on the transmit board, and is the counterpart of the receive carrier-recovery chain.
- On enable it emits a corner-only training preamble so the receive polarity phase detector can pull in. It then maps 4-bit data nibbles to I/Q levels.
- Quadrant bits are differentially encoded so the receive loop's 90° ambiguity is harmless.
- Output is held for SPS clocks per symbol (8 MHz clk, 2 Msym/s at default).

Parameters:
- SPS, 4, clocks per symbol (2..64).
- PRE_LEN, 4000, training symbols per burst (1..65535).
- OW, 12, output sample width (signed).
- AMP, 256, unit level; levels are ±AMP and ±3*AMP. 3*AMP must fit in OW signed.

Ports:
- clk  in  1  system clock, 8 MHz.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- tx_en  in  1  burst enable, level.
- din  in  4  data nibble.
- din_valid  in  1  nibble available.
- din_ready  out  1  nibble accepted this cycle when din_valid is also high.
- yi  out  OW  I sample, signed.
- yq  out  OW  Q sample, signed.
- sym_stb  out  1  one-cycle pulse on the first clock of each new output symbol.
- busy  out  1  high in TRAIN or DATA.
- underflow  out  1  sticky; set on a fill symbol, cleared when a new burst starts.

Behaviour:
- Reset (rst=0), all asynchronous:
  - state=IDLE; yi=yq=0; sym_stb=0; din_ready=0; busy=0; underflow=0.
  - Symbol counter=0; LFSR=7'h7F; quadrant reference qref=0; training counter=0.
- Symbol timing:
  - Counter runs 0..SPS-1 only in TRAIN or DATA and wraps.
  - The tick is the cycle where count==SPS-1. New yi/yq and sym_stb are registered on the clock after the tick.
  - Each symbol is held exactly SPS clocks.
- States:
  - IDLE: outputs 0. tx_en=1 → TRAIN; the counter starts at 0, so the first sym_stb comes SPS clocks later.
  - TRAIN: each tick emits one corner (±3*AMP, ±3*AMP). Quadrant = 2 LFSR output bits; the LFSR is PRBS7 x^7+x^6+1, shifted twice per symbol. qref ← emitted quadrant. After PRE_LEN symbols → DATA.
  - DATA:
    - din_ready=1 combinationally during the tick cycle only.
    - If din_valid on the tick: the nibble is consumed and mapped.
    - Otherwise: a fill symbol yi=yq=0 is emitted, underflow is set, and qref is unchanged.
  - tx_en=0 in TRAIN or DATA: the current symbol completes. On the next tick, yi=yq=0 and state → IDLE; no nibble is accepted on that tick.
  - Then LFSR, qref and training counter re-initialise. A re-assert of tx_en restarts with a full preamble.
- Mapping, differential (default):
  - din[3:2] is the Gray quadrant delta: 00→0, 01→+1, 11→+2, 10→+3 (mod 4). q = qref+delta; qref ← q.
  - din[1] selects |a| (0→AMP, 1→3*AMP); din[0] selects |b| likewise. Base point is (a,b) in quadrant 0.
  - Rotation by q·90°: q0 (a,b); q1 (-b,a); q2 (-a,-b); q3 (b,-a).
- Arithmetic: levels are constants sign-extended to OW. No saturation is needed.
- Boundaries:
  - Upstream must hold din stable while din_valid.
  - din_valid alone outside the tick gives no transfer.
  - Reset mid-symbol aborts immediately; outputs go to 0 and no partial symbol is emitted.
  - PRE_LEN=1 gives a single training symbol.

Optional Feature:
- QAM16_DIFF_EN.
  - Defined: differential quadrant mapping as above.
  - Undefined: absolute Gray mapping, qref unused. I from din[3:2] and Q from din[1:0], each 00→-3*AMP, 01→-AMP, 11→+AMP, 10→+3*AMP. The training preamble is unchanged.

Decomposition:
- Package qam16_pkg holds:
  - state encoding (IDLE/TRAIN/DATA);
  - the Gray delta table and level constants;
  - the PRBS7 seed and taps.
- One sub-module, qam16_lfsr (PRBS7 with shift-enable and synchronous re-seed), shared with the receive-side BER checker.

Test Plan:
- Reset release with tx_en=1, SPS=4, PRE_LEN=8: first sym_stb 4 clocks after the enable; 8 corner symbols with |yi|=|yq|=768, each held 4 clocks; quadrant sequence matches the PRBS7 golden model from seed 7F.
- DATA, DIFF_EN, qref=0, nibbles 4'h0,4'h7,4'hF: (256,256), then q1 base (768,768)→(-768,768), then q3 base (768,768)→(768,-768).
- DATA with din_valid=0 on one tick: yi=yq=0 for that symbol, underflow=1 and held; the next valid nibble maps against the unchanged qref.
- tx_en dropped mid-symbol in DATA: the symbol finishes its 4 clocks, then 0 output, busy=0, no din_ready pulse. Re-enable restarts a full preamble and clears underflow.
- rst pulled low two clocks into a DATA symbol: yi, yq, sym_stb and busy go to 0 asynchronously. Release with tx_en=1 replays an identical preamble.
- DIFF_EN undefined, nibble 4'hB (10,11): yi=+768, yq=+256.

Source files
------------

// File: rtl/qam16_pkg.sv
// Shared QAM16 definitions: FSM states, Gray quadrant-delta table, level multipliers, PRBS7 seed/taps.
package qam16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAIN,
    ST_DATA
  } state_t;

  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int unsigned PRBS7_TAP_HI = 6;
  localparam int unsigned PRBS7_TAP_LO = 5;

  localparam int LVL_INNER = 1;
  localparam int LVL_OUTER = 3;

  function automatic logic [1:0] gray_delta(input logic [1:0] g);
    logic [1:0] d;
    case (g)
      2'b00:   d = 2'd0;
      2'b01:   d = 2'd1;
      2'b11:   d = 2'd2;
      default: d = 2'd3;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/qam16_lfsr.sv
// PRBS7 (x^7+x^6+1) advancing two bits per enable; bits[1] is the earlier of the pair.
module qam16_lfsr
  import qam16_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic       reseed,
  output logic [1:0] bits
);

  logic [6:0] s;
  logic [6:0] s1;
  logic       b0;
  logic       b1;

  always_comb begin
    b0   = s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
    s1   = {s[5:0], b0};
    b1   = s1[PRBS7_TAP_HI] ^ s1[PRBS7_TAP_LO];
    bits = {b0, b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      s <= PRBS7_SEED;
    else if (reseed)
      s <= PRBS7_SEED;
    else if (shift_en)
      s <= {s1[5:0], b1};
  end

endmodule

// File: rtl/qam16_tx_mapper.sv
// QAM16 transmit mapper: PRBS7 corner preamble, then nibble-to-I/Q mapping held SPS clocks per symbol.
// Define QAM16_DIFF_EN for differential quadrant mapping; otherwise absolute Gray mapping.
module qam16_tx_mapper
  import qam16_pkg::*;
#(
  parameter int SPS     = 4,
  parameter int PRE_LEN = 4000,
  parameter int OW      = 12,
  parameter int AMP     = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic [3:0]           din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic signed [OW-1:0] yi,
  output logic signed [OW-1:0] yq,
  output logic                 sym_stb,
  output logic                 busy,
  output logic                 underflow
);

  localparam int CW = $clog2(SPS);
  localparam logic signed [OW-1:0] L1 = OW'(LVL_INNER * AMP);
  localparam logic signed [OW-1:0] L3 = OW'(LVL_OUTER * AMP);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [15:0]           tcnt;
  logic                  tick;
  logic [1:0]            lq;
  logic signed [OW-1:0]  cor_i, cor_q, map_i, map_q;
`ifdef QAM16_DIFF_EN
  logic [1:0]            qref;
  logic [1:0]            dq;
  logic signed [OW-1:0]  a, b;
`endif

  assign tick      = (state != ST_IDLE) && (cnt == CW'(SPS - 1));
  assign din_ready = tick && (state == ST_DATA) && tx_en;

  qam16_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (tick && (state == ST_TRAIN) && tx_en),
    .reseed   (tick && !tx_en),
    .bits     (lq)
  );

  always_comb begin
    case (lq)
      2'd0:    begin cor_i =  L3; cor_q =  L3; end
      2'd1:    begin cor_i = -L3; cor_q =  L3; end
      2'd2:    begin cor_i = -L3; cor_q = -L3; end
      default: begin cor_i =  L3; cor_q = -L3; end
    endcase
  end

`ifdef QAM16_DIFF_EN
  always_comb begin
    a  = din[1] ? L3 : L1;
    b  = din[0] ? L3 : L1;
    dq = qref + gray_delta(din[3:2]);
    case (dq)
      2'd0:    begin map_i =  a; map_q =  b; end
      2'd1:    begin map_i = -b; map_q =  a; end
      2'd2:    begin map_i = -a; map_q = -b; end
      default: begin map_i =  b; map_q = -a; end
    endcase
  end
`else
  function automatic logic signed [OW-1:0] glevel(input logic [1:0] g);
    logic signed [OW-1:0] v;
    case (g)
      2'b00:   v = -L3;
      2'b01:   v = -L1;
      2'b11:   v =  L1;
      default: v =  L3;
    endcase
    return v;
  endfunction

  always_comb begin
    map_i = glevel(din[3:2]);
    map_q = glevel(din[1:0]);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tcnt      <= '0;
      yi        <= '0;
      yq        <= '0;
      sym_stb   <= 1'b0;
      busy      <= 1'b0;
      underflow <= 1'b0;
`ifdef QAM16_DIFF_EN
      qref      <= '0;
`endif
    end else begin
      sym_stb <= 1'b0;
      if (state == ST_IDLE) begin
        cnt <= '0;
        if (tx_en) begin
          state     <= ST_TRAIN;
          busy      <= 1'b1;
          underflow <= 1'b0;
          tcnt      <= '0;
        end
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) begin
          // Disable only takes effect at a symbol boundary, and wipes burst context for the next preamble.
          if (!tx_en) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            yi    <= '0;
            yq    <= '0;
            tcnt  <= '0;
`ifdef QAM16_DIFF_EN
            qref  <= '0;
`endif
          end else if (state == ST_TRAIN) begin
            yi      <= cor_i;
            yq      <= cor_q;
            sym_stb <= 1'b1;
`ifdef QAM16_DIFF_EN
            qref    <= lq;
`endif
            if (tcnt == 16'(PRE_LEN - 1)) begin
              state <= ST_DATA;
              tcnt  <= '0;
            end else begin
              tcnt  <= tcnt + 1'b1;
            end
          end else begin
            sym_stb <= 1'b1;
            if (din_valid) begin
              yi   <= map_i;
              yq   <= map_q;
`ifdef QAM16_DIFF_EN
              qref <= dq;
`endif
            end else begin
              yi        <= '0;
              yq        <= '0;
              underflow <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_qam16_tx_mapper.sv
// Directed bench for qam16_tx_mapper (SPS=4, PRE_LEN=8); expectations follow QAM16_DIFF_EN when defined.
module tb_qam16_tx_mapper;

  localparam int SPS = 4;
  localparam int PRE = 8;
  localparam int OW  = 12;
  localparam int AMP = 256;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 tx_en = 1'b0;
  logic [3:0]           din = 4'h0;
  logic                 din_valid = 1'b0;
  logic                 din_ready;
  logic signed [OW-1:0] yi, yq;
  logic                 sym_stb, busy, underflow;

  int n_cmp = 0;
  int n_err = 0;

  // PRBS7 from 7F, two bits per symbol (first bit is MSB): quadrants 0,0,0,2,0,0,3,0
  int tr_i[PRE] = '{768, 768, 768, -768, 768, 768, 768, 768};
  int tr_q[PRE] = '{768, 768, 768, -768, 768, 768, -768, 768};

  // Nibbles 0,7,F then B after a fill symbol
`ifdef QAM16_DIFF_EN
  int d_i[4] = '{256, -768, 768, -768};
  int d_q[4] = '{256, 768, -768, -768};
`else
  int d_i[4] = '{-768, -256, 256, 768};
  int d_q[4] = '{-768, 256, 256, 256};
`endif

  qam16_tx_mapper #(
    .SPS     (SPS),
    .PRE_LEN (PRE),
    .OW      (OW),
    .AMP     (AMP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .yi        (yi),
    .yq        (yq),
    .sym_stb   (sym_stb),
    .busy      (busy),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Waits for the next sym_stb (bounded), checking gap, new value, hold of the old value and ready pulses.
  task automatic next_sym(input string tag, input int gap, input int ei, input int eq, input int erdy);
    int n;
    int rdy;
    int held;
    logic signed [OW-1:0] pi, pq;
    n = 0; rdy = 0; held = 1; pi = yi; pq = yq;
    do begin
      @(posedge clk); #1;
      n++;
      if (!sym_stb) begin
        if (yi != pi || yq != pq) held = 0;
        if (din_ready) rdy++;
      end
    end while (!sym_stb && n < 64);
    check({tag, "_gap"}, n, gap);
    check({tag, "_i"}, yi, ei);
    check({tag, "_q"}, yq, eq);
    check({tag, "_hold"}, held, 1);
    check({tag, "_rdy"}, rdy, erdy);
  endtask

  initial begin
    int rdy;
    int held;

    repeat (3) @(posedge clk);
    #1;
    check("rst_yi", yi, 0);
    check("rst_yq", yq, 0);
    check("rst_stb", sym_stb, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", din_ready, 0);
    check("rst_unf", underflow, 0);

    @(negedge clk);
    tx_en = 1'b1;
    rst   = 1'b1;
    for (int k = 0; k < PRE; k++)
      next_sym($sformatf("trn%0d", k), (k == 0) ? SPS + 1 : SPS, tr_i[k], tr_q[k], 0);
    check("trn_busy", busy, 1);

    din = 4'h0; din_valid = 1'b1;
    next_sym("d0", SPS, d_i[0], d_q[0], 1);
    check("d0_unf", underflow, 0);
    din = 4'h7;
    next_sym("d1", SPS, d_i[1], d_q[1], 1);
    din = 4'hF;
    next_sym("d2", SPS, d_i[2], d_q[2], 1);
    din_valid = 1'b0;
    next_sym("fill", SPS, 0, 0, 1);
    check("fill_unf", underflow, 1);
    din = 4'hB; din_valid = 1'b1;
    next_sym("d3", SPS, d_i[3], d_q[3], 1);
    check("d3_unf", underflow, 1);

    din = 4'h5;
    @(negedge clk);
    tx_en = 1'b0;
    rdy = 0; held = 1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (din_ready) rdy++;
      if (i < 4 && (yi != 12'(d_i[3]) || yq != 12'(d_q[3]) || sym_stb || !busy)) held = 0;
    end
    check("stop_hold", held, 1);
    check("stop_rdy", rdy, 0);
    check("stop_yi", yi, 0);
    check("stop_yq", yq, 0);
    check("stop_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_unf", underflow, 1);
    check("idle_yi", yi, 0);

    @(negedge clk);
    tx_en = 1'b1; din_valid = 1'b0;
    for (int k = 0; k < PRE; k++) begin
      next_sym($sformatf("re%0d", k), (k == 0) ? SPS + 1 : SPS, tr_i[k], tr_q[k], 0);
      if (k == 0) check("re_unf", underflow, 0);
    end
    din = 4'h0; din_valid = 1'b1;
    next_sym("re_d0", SPS, d_i[0], d_q[0], 1);

    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_yi", yi, 0);
    check("arst_yq", yq, 0);
    check("arst_stb", sym_stb, 0);
    check("arst_busy", busy, 0);
    check("arst_rdy", din_ready, 0);

    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0;
    for (int k = 0; k < PRE; k++)
      next_sym($sformatf("rp%0d", k), (k == 0) ? SPS + 1 : SPS, tr_i[k], tr_q[k], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
